gated_edge_counter: RTL

GATED_EDGE_COUNTER -- requirements
Module: gated_edge_counter

---
 rtl/gated_edge_counter_pkg.sv | 15 +
 rtl/gated_edge_counter_rise_detect.sv | 24 ++
 rtl/gated_edge_counter.sv | 108 ++++++++++
 3 files changed

// File: rtl/gated_edge_counter_pkg.sv
// Shared types and defaults for the gated edge counter: FSM states and
// parameter defaults used by the top and its edge detector.
package gated_edge_counter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int CNT_W_DEFAULT   = 8;
  localparam int WIN_LEN_DEFAULT = 16;
  localparam int WIN_CNT_W       = 16;

endpackage

// File: rtl/gated_edge_counter_rise_detect.sv
// Rising-edge detector: registers the previous input value every cycle and
// flags the cycle where the input goes from 0 to 1.
module rise_detect
  import gated_edge_counter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      d_prev <= 1'b0;
    end else begin
      d_prev <= d;
    end
  end

  assign rise = d & ~d_prev;

endmodule

// File: rtl/gated_edge_counter.sv
// Counts rising edges of y_in over a fixed window of WIN_LEN cycles after a
// start request, then holds the saturating count until the consumer accepts it.
module gated_edge_counter
  import gated_edge_counter_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEFAULT,
  parameter int WIN_LEN = WIN_LEN_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             y_in,
  output logic             busy,
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid,
  input  logic             count_ready,
  output logic             overflow
);

  localparam logic [WIN_CNT_W-1:0] WIN_LOAD = WIN_CNT_W'(WIN_LEN - 1);
  localparam logic [WIN_CNT_W-1:0] WIN_ONE  = WIN_CNT_W'(1);
  localparam logic [CNT_W-1:0]     CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);

  state_t               state;
  state_t               next_state;
  logic [WIN_CNT_W-1:0] win_cnt;
  logic [CNT_W-1:0]     edge_cnt;
  logic                 ovf;
  logic                 rise;

  // The edge history runs in every state, so the first window cycle sees
  // the y_in value from the cycle in which start was sampled.
  rise_detect u_rise_detect (
    .clk  (clk),
    .rst  (rst),
    .d    (y_in),
    .rise (rise)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      win_cnt  <= '0;
      edge_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (start) begin
            edge_cnt <= '0;
            ovf      <= 1'b0;
            win_cnt  <= WIN_LOAD;
          end
        end
        COUNT: begin
          // An edge that finds the count already saturated only marks overflow.
          if (rise) begin
            if (edge_cnt == CNT_MAX) begin
              ovf <= 1'b1;
            end else begin
              edge_cnt <= edge_cnt + CNT_ONE;
            end
          end
          if (win_cnt != '0) begin
            win_cnt <= win_cnt - WIN_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    next_state  = state;
    busy        = 1'b0;
    count_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = COUNT;
        end
      end
      COUNT: begin
        busy = 1'b1;
        if (win_cnt == '0) begin
          next_state = HOLD;
        end
      end
      HOLD: begin
        busy        = 1'b1;
        count_valid = 1'b1;
        if (count_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign count_out = edge_cnt;
  assign overflow  = ovf;

endmodule
